// File: rtl/pc_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : pc_fetch_pkg
//  Purpose : Shared definitions for the instruction-fetch stage: FSM state
//            encoding, fetch exception codes, word constants, and the
//            address-alignment helper used on every fetch address.
//  Ports   : none (package)
//  Rev     : 1.0  initial release
// ============================================================================
package pc_fetch_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;

  localparam logic [1:0] EXC_NONE       = 2'b00;
  localparam logic [1:0] EXC_FETCH_ADDR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } fetch_state_e;

  // Without the alignment checker the low address bits are simply dropped,
  // so a misaligned target silently fetches the enclosing word.
  function automatic logic [INST_W-1:0] align_pc(input logic [INST_W-1:0] pc);
`ifdef PC_ALIGN_CHECK_EN
    return pc;
`else
    return {pc[INST_W-1:2], 2'b00};
`endif
  endfunction

endpackage : pc_fetch_pkg
`default_nettype wire

// File: rtl/pc_fetch_pc_next_sel.sv
`default_nettype none
// ============================================================================
//  Module  : pc_next_sel
//  Purpose : Combinational next-PC selection. Exception flush beats a taken
//            branch; otherwise the sequential PC+4 (wrapping at 2^32).
//            Honours PC_ALIGN_CHECK_EN through pc_fetch_pkg::align_pc.
//  Ports   : flush_i/new_pc_i          exception redirect and target
//            branch_flag_i/branch_target_i  branch redirect and target
//            cur_pc_i                  current fetch PC
//            redirect_o                any redirect requested this cycle
//            redirect_pc_o             winning redirect target
//            seq_pc_o                  cur_pc_i + 4
//  Rev     : 1.0  initial release
// ============================================================================
module pc_next_sel
  import pc_fetch_pkg::*;
(
  input  logic              flush_i,
  input  logic [INST_W-1:0] new_pc_i,
  input  logic              branch_flag_i,
  input  logic [INST_W-1:0] branch_target_i,
  input  logic [INST_W-1:0] cur_pc_i,
  output logic              redirect_o,
  output logic [INST_W-1:0] redirect_pc_o,
  output logic [INST_W-1:0] seq_pc_o
);

  always_comb begin
    redirect_o    = flush_i | branch_flag_i;
    redirect_pc_o = align_pc(flush_i ? new_pc_i : branch_target_i);
    // Natural 32-bit overflow gives the FFFF_FFFC -> 0000_0000 wrap.
    seq_pc_o      = align_pc(cur_pc_i + 32'd4);
  end

endmodule : pc_next_sel
`default_nettype wire

// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
//  Module  : pc_fetch
//  Purpose : Instruction fetch stage. Issues one outstanding request at a
//            time to instruction memory, presents the returned word with its
//            PC one cycle after ack, and handles redirects (flush/branch),
//            squashes and downstream back-pressure.
//            Optional macro PC_ALIGN_CHECK_EN: misaligned redirect targets
//            raise a fetch-address exception instead of being word-aligned.
//  Ports   : clk, rst_n                 clock, async active-low reset
//            flush_i/new_pc_i           exception redirect
//            branch_flag_i/branch_target_i  taken-branch redirect
//            pc_instr_invalid_i         squash of the word returning now
//            stall_i                    downstream cannot accept
//            inst_req_o/inst_addr_o     memory request and address
//            inst_ack_i/inst_data_i     memory ack and instruction word
//            pc_o/instr_o/instr_valid_o/excepttype_o  fetched result
//  Rev     : 1.0  initial release
// ============================================================================
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned EXC_VECTOR_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush_i,
  input  logic [31:0]             new_pc_i,
  input  logic                    branch_flag_i,
  input  logic [31:0]             branch_target_i,
  input  logic                    pc_instr_invalid_i,
  input  logic                    stall_i,
  output logic                    inst_req_o,
  output logic [31:0]             inst_addr_o,
  input  logic                    inst_ack_i,
  input  logic [31:0]             inst_data_i,
  output logic [31:0]             pc_o,
  output logic [31:0]             instr_o,
  output logic                    instr_valid_o,
  output logic [EXC_VECTOR_W-1:0] excepttype_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  pend_pc_q, pend_pc_d;   // redirect target held while killed request drains
  logic         kill_q, kill_d;
  logic         fault_q, fault_d;       // parked after an address fault until a redirect
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         valid_q, valid_d;

  logic         req;
  logic         load_en;
  logic         load_bad;
  logic [31:0]  load_pc;
  logic         redirect;
  logic [31:0]  redirect_pc;
  logic [31:0]  seq_pc;

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [EXC_VECTOR_W-1:0] EXC_ADDR_ERR = EXC_VECTOR_W'(EXC_FETCH_ADDR);
  localparam logic [EXC_VECTOR_W-1:0] EXC_CLEAR    = EXC_VECTOR_W'(EXC_NONE);
  logic [EXC_VECTOR_W-1:0] exc_q, exc_d;
  assign load_bad = |load_pc[1:0];
`else
  assign load_bad = 1'b0;
`endif

  pc_next_sel u_pc_next_sel (
    .flush_i         (flush_i),
    .new_pc_i        (new_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .cur_pc_i        (fetch_pc_q),
    .redirect_o      (redirect),
    .redirect_pc_o   (redirect_pc),
    .seq_pc_o        (seq_pc)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    kill_d     = kill_q;
    fault_d    = fault_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    // A presented word is consumed on any cycle without stall.
    valid_d    = valid_q & stall_i;
`ifdef PC_ALIGN_CHECK_EN
    exc_d      = exc_q;
`endif
    req        = 1'b0;
    load_en    = 1'b0;
    load_pc    = redirect_pc;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
        if (redirect) load_en = 1'b1;
      end

      ST_REQ: begin
        // A fresh request is only raised while the output slot is free, so
        // an ack can never land on an unconsumed word.
        if (valid_q && stall_i) begin
          if (redirect) begin
            valid_d = 1'b0;
            load_en = 1'b1;
          end else begin
            state_d = ST_HOLD;
          end
        end else begin
          req = 1'b1;
          if (inst_ack_i) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              load_en = 1'b1;
              if (!redirect) load_pc = pend_pc_q;
            end else if (redirect) begin
              // Word returning now is on the wrong path.
              load_en = 1'b1;
            end else begin
              fetch_pc_d = seq_pc;
              if (!pc_instr_invalid_i) begin
                valid_d = 1'b1;
                pc_d    = fetch_pc_q;
                instr_d = inst_data_i;
`ifdef PC_ALIGN_CHECK_EN
                exc_d   = EXC_CLEAR;
`endif
              end
            end
          end else if (redirect) begin
            // Memory still owes us this word: keep the request stable and
            // drop its data when it arrives.
            kill_d    = 1'b1;
            pend_pc_d = redirect_pc;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          valid_d = 1'b0;
          load_en = 1'b1;
        end else if (!stall_i && !fault_q) begin
          state_d = ST_REQ;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (load_en) begin
      fetch_pc_d = load_pc;
      if (load_bad) begin
        // Report the bad target as a completed fetch carrying an exception;
        // no memory access is made and fetch waits for the next redirect.
        state_d = ST_HOLD;
        fault_d = 1'b1;
        valid_d = 1'b1;
        pc_d    = load_pc;
        instr_d = ZERO_WORD;
`ifdef PC_ALIGN_CHECK_EN
        exc_d   = EXC_ADDR_ERR;
`endif
      end else begin
        state_d = ST_REQ;
        fault_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= align_pc(RESET_PC);
      pend_pc_q  <= ZERO_WORD;
      kill_q     <= 1'b0;
      fault_q    <= 1'b0;
      pc_q       <= ZERO_WORD;
      instr_q    <= ZERO_WORD;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      kill_q     <= kill_d;
      fault_q    <= fault_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exc_q <= '0;
    else        exc_q <= exc_d;
  end
  assign excepttype_o = exc_q;
`else
  assign excepttype_o = '0;
`endif

  assign inst_req_o    = req;
  assign inst_addr_o   = fetch_pc_q;
  assign pc_o          = pc_q;
  assign instr_o       = instr_q;
  assign instr_valid_o = valid_q;

endmodule : pc_fetch
`default_nettype wire
